// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and status codes for the instruction-memory boot loader.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_CSUM  = 3'd4,
    ST_CLEAR = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } ld_state_t;

  localparam logic [1:0] LD_ERR_NONE = 2'd0;
  localparam logic [1:0] LD_ERR_LEN  = 2'd1;
  localparam logic [1:0] LD_ERR_CSUM = 2'd2;

  localparam int LD_HDR_W = 8;

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
// imem_ram: instruction memory, one synchronous write port and one combinational read port for fetch.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none
module imem_ram #(
  parameter int IMEM_DEPTH = 8,
  parameter int IMEM_AW    = $clog2(IMEM_DEPTH),
  parameter int DWL        = 16
) (
  input  logic               CLK,
  input  logic               we,
  input  logic [IMEM_AW-1:0] wa,
  input  logic [DWL-1:0]     wd,
  input  logic [IMEM_AW-1:0] ra,
  output logic [DWL-1:0]     rd
);

  logic [DWL-1:0] mem [IMEM_DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd = mem[ra];

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream, writes 16-bit words into instruction memory, holds the core in reset until verified.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 8,
  parameter int IMEM_AW    = $clog2(IMEM_DEPTH),
  parameter int DWL        = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_wa,
  output logic [DWL-1:0]     imem_wd,
  output logic               core_rst,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code
);

  localparam logic [LD_HDR_W-1:0] DEPTH_N   = LD_HDR_W'(IMEM_DEPTH);
  localparam logic [IMEM_AW-1:0]  LAST_ADDR = IMEM_AW'(IMEM_DEPTH - 1);

  ld_state_t             state, state_n;
  logic [LD_HDR_W-1:0]   n_words, n_words_n;
  logic [IMEM_AW-1:0]    idx, idx_n;
  logic [7:0]            hi_byte, hi_byte_n;
  logic [7:0]            xor_acc, xor_acc_n;
  logic                  we_n, core_rst_n, busy_n, done_n, err_n;
  logic [IMEM_AW-1:0]    wa_n;
  logic [DWL-1:0]        wd_n;
  logic [1:0]            err_code_n;
  logic                  accept;
  logic                  last_word;

  assign rx_ready  = (state == ST_HDR) || (state == ST_HI) ||
                     (state == ST_LO)  || (state == ST_CSUM);
  assign accept    = rx_valid && rx_ready;
  assign last_word = (LD_HDR_W'(idx) + LD_HDR_W'(1)) == n_words;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      n_words  <= '0;
      idx      <= '0;
      hi_byte  <= '0;
      xor_acc  <= '0;
      imem_we  <= 1'b0;
      imem_wa  <= '0;
      imem_wd  <= '0;
      core_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= LD_ERR_NONE;
    end else begin
      state    <= state_n;
      n_words  <= n_words_n;
      idx      <= idx_n;
      hi_byte  <= hi_byte_n;
      xor_acc  <= xor_acc_n;
      imem_we  <= we_n;
      imem_wa  <= wa_n;
      imem_wd  <= wd_n;
      core_rst <= core_rst_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      err_code <= err_code_n;
    end
  end

  always_comb begin
    state_n    = state;
    n_words_n  = n_words;
    idx_n      = idx;
    hi_byte_n  = hi_byte;
    xor_acc_n  = xor_acc;
    we_n       = 1'b0;
    wa_n       = imem_wa;
    wd_n       = imem_wd;
    core_rst_n = core_rst;
    busy_n     = busy;
    done_n     = done;
    err_n      = err;
    err_code_n = err_code;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_n    = ST_HDR;
          busy_n     = 1'b1;
          core_rst_n = 1'b1;
          done_n     = 1'b0;
          err_n      = 1'b0;
          err_code_n = LD_ERR_NONE;
          idx_n      = '0;
          xor_acc_n  = '0;
        end
      end
      ST_HDR: begin
        if (accept) begin
          if (rx_data == '0 || rx_data > DEPTH_N) begin
            state_n    = ST_ERR;
            busy_n     = 1'b0;
            err_n      = 1'b1;
            err_code_n = LD_ERR_LEN;
          end else begin
            n_words_n = rx_data;
            state_n   = ST_HI;
          end
        end
      end
      ST_HI: begin
        if (accept) begin
          hi_byte_n = rx_data;
          xor_acc_n = xor_acc ^ rx_data;
          state_n   = ST_LO;
        end
      end
      ST_LO: begin
        if (accept) begin
          xor_acc_n = xor_acc ^ rx_data;
          we_n      = 1'b1;
          wa_n      = idx;
          wd_n      = DWL'({hi_byte, rx_data});
          idx_n     = idx + IMEM_AW'(1);
          state_n   = last_word ? ST_CSUM : ST_HI;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (rx_data != xor_acc) begin
            state_n    = ST_ERR;
            busy_n     = 1'b0;
            err_n      = 1'b1;
            err_code_n = LD_ERR_CSUM;
          end else if (n_words < DEPTH_N) begin
            // idx already equals N here, so it doubles as the zero-fill address
            state_n = ST_CLEAR;
          end else begin
            state_n    = ST_DONE;
            busy_n     = 1'b0;
            done_n     = 1'b1;
            core_rst_n = 1'b0;
          end
        end
      end
      ST_CLEAR: begin
        we_n  = 1'b1;
        wa_n  = idx;
        wd_n  = '0;
        idx_n = idx + IMEM_AW'(1);
        if (idx == LAST_ADDR) begin
          state_n    = ST_DONE;
          busy_n     = 1'b0;
          done_n     = 1'b1;
          core_rst_n = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors, hand sequences and random frames checked against a frame-level reference model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, imem_we, core_rst, busy, done, err;
  logic [AW-1:0] imem_wa;
  logic [DW-1:0] imem_wd;
  logic [1:0]    err_code;
  logic [AW-1:0] ra = '0;
  logic [DW-1:0] rd;

  imem_loader #(.IMEM_DEPTH(DEPTH), .IMEM_AW(AW), .DWL(DW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_wa(imem_wa), .imem_wd(imem_wd),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  imem_ram #(.IMEM_DEPTH(DEPTH), .IMEM_AW(AW), .DWL(DW)) ram (
    .CLK(CLK), .we(imem_we), .wa(imem_wa), .wd(imem_wd), .ra(ra), .rd(rd)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int rst_viol = 0;
  bit mon_on = 1'b0;

  logic [AW+DW-1:0] got_wr[$];
  logic [AW+DW-1:0] exp_wr[$];
  logic [7:0]       got_acc[$];
  logic [7:0]       cur[$];
  logic [DW-1:0]    ref_mem [DEPTH];
  bit               m_done, m_err;
  logic [1:0]       m_code;
  int               m_cons;

  typedef struct {
    logic [8*18-1:0] bytes;
    int              len;
    int              gap;
    bit              e_done;
    bit              e_err;
    logic [1:0]      e_code;
    int              e_nwr;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Frame-level model: writes, final status and how many bytes the loader consumes.
  task automatic model_frame();
    int n;
    logic [7:0] x, hi, lo;
    exp_wr.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    m_code = LD_ERR_NONE;
    n      = int'(cur[0]);
    if (n == 0 || n > DEPTH) begin
      m_err  = 1'b1;
      m_code = LD_ERR_LEN;
      m_cons = 1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      hi = cur[1 + 2*i];
      lo = cur[2 + 2*i];
      x  = x ^ hi ^ lo;
      exp_wr.push_back({AW'(i), hi, lo});
    end
    m_cons = 2*n + 2;
    if (cur[2*n + 1] != x) begin
      m_err  = 1'b1;
      m_code = LD_ERR_CSUM;
      return;
    end
    for (int a = n; a < DEPTH; a++) exp_wr.push_back({AW'(a), 16'h0000});
    m_done = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (mon_on) begin
      if (imem_we) got_wr.push_back({imem_wa, imem_wd});
      if (rx_valid && rx_ready) got_acc.push_back(rx_data);
      if (core_rst == done) rst_viol++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start, output bit ok);
    bit a;
    int t;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      @(posedge CLK); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    start    = pulse_start;
    a = 1'b0;
    t = 0;
    while (!a && t < 50) begin
      @(negedge CLK);
      a = rx_ready;
      @(posedge CLK); #1;
      start = 1'b0;
      t++;
    end
    rx_valid = 1'b0;
    ok = a;
  endtask

  task automatic run_frame(input string nm, input int gap, input int start_at);
    bit ok;
    int t, gp, nw, na;
    model_frame();
    got_wr.delete();
    got_acc.delete();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < m_cons && ok; i++) begin
      gp = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      send_byte(cur[i], gp, (i == start_at), ok);
    end
    chk({nm, "_accepted"}, 32'(ok), 32'd1);
    t = 0;
    while (busy && t < 100) begin
      @(posedge CLK); #1;
      t++;
    end
    repeat (3) begin @(posedge CLK); #1; end
    chk({nm, "_busy"},     32'(busy),     32'd0);
    chk({nm, "_done"},     32'(done),     32'(m_done));
    chk({nm, "_err"},      32'(err),      32'(m_err));
    chk({nm, "_err_code"}, 32'(err_code), 32'(m_code));
    chk({nm, "_core_rst"}, 32'(core_rst), 32'(!m_done));
    chk({nm, "_rx_ready"}, 32'(rx_ready), 32'd0);
    nw = got_wr.size();
    na = got_acc.size();
    chk({nm, "_nwrites"}, 32'(nw), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      chk($sformatf("%s_write%0d", nm, i), (i < nw) ? 32'(got_wr[i]) : 32'hxxxxxxxx, 32'(exp_wr[i]));
    chk({nm, "_naccepted"}, 32'(na), 32'(m_cons));
    for (int i = 0; i < m_cons; i++)
      chk($sformatf("%s_byte%0d", nm, i), (i < na) ? 32'(got_acc[i]) : 32'hxxxxxxxx, 32'(cur[i]));
    foreach (exp_wr[i]) ref_mem[exp_wr[i][DW+AW-1:DW]] = exp_wr[i][DW-1:0];
    if (m_done) begin
      for (int a = 0; a < DEPTH; a++) begin
        ra = AW'(a);
        #1;
        chk($sformatf("%s_mem%0d", nm, a), 32'(rd), 32'(ref_mem[a]));
      end
    end
  endtask

  task automatic load_vec(input int k);
    cur.delete();
    for (int i = 0; i < vecs[k].len; i++)
      cur.push_back(vecs[k].bytes[8*(vecs[k].len - 1 - i) +: 8]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    vecs[0] = '{144'h0301050213731274, 8, 0, 1'b1, 1'b0, LD_ERR_NONE, 8};
    vecs[1] = '{144'h0301050213731274, 8, 2, 1'b1, 1'b0, LD_ERR_NONE, 8};
    vecs[2] = '{144'h0301050213731275, 8, 0, 1'b0, 1'b1, LD_ERR_CSUM, 3};
    vecs[3] = '{144'h00,               1, 0, 1'b0, 1'b1, LD_ERR_LEN,  0};
    vecs[4] = '{144'h09,               1, 0, 1'b0, 1'b1, LD_ERR_LEN,  0};
    vecs[5] = '{144'h08_0102_0304_0506_0708_090A_0B0C_0D0E_0F10_10, 18, 0, 1'b1, 1'b0, LD_ERR_NONE, 8};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_imem_we",  32'(imem_we),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_imem_wa",  32'(imem_wa),  32'd0);
    chk("rst_imem_wd",  32'(imem_wd),  32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    RST = 1'b0;
    mon_on = 1'b1;

    for (int k = 0; k < 6; k++) begin
      load_vec(k);
      run_frame($sformatf("vec%0d", k), vecs[k].gap, -1);
      chk($sformatf("vec%0d_tbl_done", k), 32'(done),          32'(vecs[k].e_done));
      chk($sformatf("vec%0d_tbl_err", k),  32'(err),           32'(vecs[k].e_err));
      chk($sformatf("vec%0d_tbl_code", k), 32'(err_code),      32'(vecs[k].e_code));
      chk($sformatf("vec%0d_tbl_nwr", k),  32'(got_wr.size()), 32'(vecs[k].e_nwr));
    end

    // start pulsed mid-frame must not disturb the session
    load_vec(0);
    run_frame("start_while_busy", 0, 3);

    // reset after the second word, then a clean reload
    load_vec(0);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_byte(cur[i], 0, 1'b0, ok);
      chk($sformatf("rst_seq_byte%0d", i), 32'(ok), 32'd1);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    chk("midrst_busy",     32'(busy),     32'd0);
    chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
    chk("midrst_done",     32'(done),     32'd0);
    chk("midrst_imem_we",  32'(imem_we),  32'd0);
    repeat (2) begin @(posedge CLK); #1; end
    chk("midrst_idle_ready", 32'(rx_ready), 32'd0);
    run_frame("midrst_restart", 0, -1);

    for (int r = 0; r < 25; r++) begin
      int n;
      logic [7:0] x, b;
      cur.delete();
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = int'($urandom_range(9, 255));
        default: n = int'($urandom_range(1, 8));
      endcase
      cur.push_back(8'(n));
      x = 8'h00;
      if (n >= 1 && n <= DEPTH) begin
        for (int i = 0; i < 2*n; i++) begin
          b = 8'($urandom);
          cur.push_back(b);
          x = x ^ b;
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        cur.push_back(x);
      end
      run_frame($sformatf("rnd%0d", r), -1, -1);
    end

    chk("core_rst_only_in_done", 32'(rst_viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
